// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pc_sequencer                                               |
// | Description : Fetch PC register with next-PC select and a valid-tagged   |
// |               PC+INC link chain feeding the MEM stage.                   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module pc_sequencer #(
   parameter int               XLEN         = 32,
   parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
   parameter int               INC          = 4,
   parameter int               LINK_STAGES  = 3,
   parameter int               HOLD_STAGES  = 1,
   parameter int               KILL_STAGES  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              pred_taken_i,
   input  logic [XLEN-1:0]   pred_target_i,
   input  logic              redirect_i,
   input  logic [XLEN-1:0]   redirect_pc_i,
   output logic [XLEN-1:0]   pc_o,
   output logic              link_valid_o,
   output logic [XLEN-1:0]   link_pc_o,
   output logic              misalign_o,
   output logic [15:0]       redirect_cnt_o
);

   localparam logic [XLEN-1:0] c_inc     = XLEN'(INC);
   localparam logic [15:0]     c_cnt_max = 16'hFFFF;

   logic [XLEN-1:0]        r_pc;
   logic [XLEN-1:0]        w_pc_next;
   logic [XLEN-1:0]        w_pc_inc;
   logic                   r_misalign;
   logic [15:0]            r_cnt;

   logic [LINK_STAGES:1]   r_valid;
   logic [LINK_STAGES:1]   w_src_valid;
   logic [LINK_STAGES:1]   w_valid_next;
   logic [XLEN-1:0]        r_data      [1:LINK_STAGES];
   logic [XLEN-1:0]        w_src_data  [1:LINK_STAGES];
   logic [XLEN-1:0]        w_data_next [1:LINK_STAGES];

   assign w_pc_inc = r_pc + c_inc;

   always_comb begin
      w_pc_next = w_pc_inc;
      if (redirect_i)
         w_pc_next = {redirect_pc_i[XLEN-1:2], 2'b00};
      else if (stall_i)
         w_pc_next = r_pc;
      else if (pred_taken_i)
         w_pc_next = pred_target_i;
   end

   // What each stage would capture on a plain advance; stage 1 sees the fetch slot.
   assign w_src_valid = {r_valid[LINK_STAGES-1:1], 1'b1};

   always_comb begin
      w_src_data[1] = w_pc_inc;
      for (int k = 2; k <= LINK_STAGES; k++)
         w_src_data[k] = r_data[k-1];
   end

   always_comb begin
      for (int k = 1; k <= LINK_STAGES; k++) begin
         w_valid_next[k] = w_src_valid[k];
         w_data_next[k]  = w_src_data[k];
         if (redirect_i) begin
            if (k <= KILL_STAGES) begin
               w_valid_next[k] = 1'b0;
               w_data_next[k]  = '0;
            end
         end else if (stall_i) begin
            if (k <= HOLD_STAGES) begin
               w_valid_next[k] = r_valid[k];
               w_data_next[k]  = r_data[k];
            end else if (k == HOLD_STAGES + 1) begin
               w_valid_next[k] = 1'b0;
               w_data_next[k]  = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc       <= RESET_VECTOR;
         r_misalign <= 1'b0;
         r_cnt      <= '0;
         r_valid    <= '0;
         for (int k = 1; k <= LINK_STAGES; k++)
            r_data[k] <= '0;
      end else begin
         r_pc       <= w_pc_next;
         r_misalign <= redirect_i & redirect_pc_i[1];
         if (redirect_i && (r_cnt != c_cnt_max))
            r_cnt <= r_cnt + 16'd1;
         r_valid    <= w_valid_next;
         for (int k = 1; k <= LINK_STAGES; k++)
            r_data[k] <= w_data_next[k];
      end
   end

   assign pc_o           = r_pc;
   assign link_valid_o   = r_valid[LINK_STAGES];
   assign link_pc_o      = r_data[LINK_STAGES];
   assign misalign_o     = r_misalign;
   assign redirect_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pc_sequencer                                            |
// | Description : Directed plus random stimulus against a pipeline model.    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_pc_sequencer;

   localparam int L = 3;
   localparam int H = 1;
   localparam int K = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i, pred_taken_i, redirect_i;
   logic [31:0] pred_target_i, redirect_pc_i;
   logic [31:0] pc_o, link_pc_o;
   logic        link_valid_o, misalign_o;
   logic [15:0] redirect_cnt_o;

   int checks = 0;
   int errors = 0;

   // Model: the instruction line in flight, slot 1 youngest, slot L at MEM.
   logic [31:0] m_pc;
   logic        m_v [1:L];
   logic [31:0] m_d [1:L];
   logic        m_mis;
   int          m_cnt;

   pc_sequencer dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .pred_taken_i(pred_taken_i),
      .pred_target_i(pred_target_i), .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i), .pc_o(pc_o), .link_valid_o(link_valid_o),
      .link_pc_o(link_pc_o), .misalign_o(misalign_o), .redirect_cnt_o(redirect_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc  = 32'h0;
      m_mis = 1'b0;
      m_cnt = 0;
      for (int k = 1; k <= L; k++) begin
         m_v[k] = 1'b0;
         m_d[k] = 32'h0;
      end
   endtask

   task automatic chk_all();
      chk("pc", pc_o, m_pc);
      chk("link_valid", {31'h0, link_valid_o}, {31'h0, m_v[L]});
      chk("link_pc", link_pc_o, m_d[L]);
      chk("misalign", {31'h0, misalign_o}, {31'h0, m_mis});
      chk("redirect_cnt", {16'h0, redirect_cnt_o}, m_cnt[31:0]);
   endtask

   // Line update: fetch enters at the young end, instructions move toward MEM;
   // a stall splits the line after the held part with a bubble; a redirect
   // replaces the young part with bubbles.
   task automatic model_edge(input logic st, input logic pt, input logic [31:0] tg,
                             input logic rd, input logic [31:0] rp);
      logic        ov [0:L];
      logic [31:0] od [0:L];
      ov[0] = 1'b1;
      od[0] = m_pc + 32'd4;
      for (int k = 1; k <= L; k++) begin
         ov[k] = m_v[k];
         od[k] = m_d[k];
      end
      for (int k = 1; k <= L; k++) begin
         if (rd && k <= K) begin
            m_v[k] = 1'b0; m_d[k] = 32'h0;
         end else if (!rd && st && k <= H) begin
            m_v[k] = ov[k]; m_d[k] = od[k];
         end else if (!rd && st && k == H + 1) begin
            m_v[k] = 1'b0; m_d[k] = 32'h0;
         end else begin
            m_v[k] = ov[k-1]; m_d[k] = od[k-1];
         end
      end
      m_mis = rd & rp[1];
      if (rd) begin
         m_pc = rp & 32'hFFFF_FFFC;
         if (m_cnt < 65535) m_cnt++;
      end else if (!st) begin
         m_pc = pt ? tg : m_pc + 32'd4;
      end
   endtask

   task automatic step(input logic st, input logic pt, input logic [31:0] tg,
                       input logic rd, input logic [31:0] rp);
      stall_i = st; pred_taken_i = pt; pred_target_i = tg;
      redirect_i = rd; redirect_pc_i = rp;
      @(posedge clk);
      model_edge(st, pt, tg, rd, rp);
      #1;
      chk_all();
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      stall_i = 1'b0; pred_taken_i = 1'b0; redirect_i = 1'b0;
      pred_target_i = 32'h0; redirect_pc_i = 32'h0;
      model_reset();
      @(negedge clk);
      chk_all();
      rst = 1'b0;

      // Free run and predictor hop at pc 8
      chk("fr_pc0", pc_o, 32'h0);
      idle();
      chk("fr_pc1", pc_o, 32'h4);
      idle();
      chk("fr_pc2", pc_o, 32'h8);
      step(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
      chk("pred_pc", pc_o, 32'h100);
      chk("first_link_v", {31'h0, link_valid_o}, 32'h1);
      chk("first_link_pc", link_pc_o, 32'h4);
      idle();
      chk("link_pc8", link_pc_o, 32'h8);
      idle();
      chk("link_pc12", link_pc_o, 32'hC);
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
      chk("redir_pc", pc_o, 32'h40);
      chk("redir_cnt", {16'h0, redirect_cnt_o}, 32'h1);
      idle();
      chk("kill_v0", {31'h0, link_valid_o}, 32'h0);
      chk("kill_pc0", link_pc_o, 32'h0);
      idle();
      chk("kill_v1", {31'h0, link_valid_o}, 32'h0);
      idle();

      // Two-cycle stall at pc 0x20
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'h18);
      idle();
      idle();
      chk("pre_stall_pc", pc_o, 32'h20);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("stall_pc0", pc_o, 32'h20);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("stall_pc1", pc_o, 32'h20);
      for (int i = 0; i < 5; i++) idle();

      // Redirect with stall, misaligned target
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h82);
      chk("rs_pc", pc_o, 32'h80);
      chk("rs_mis", {31'h0, misalign_o}, 32'h1);
      idle();
      chk("rs_mis_off", {31'h0, misalign_o}, 32'h0);

      // Wrap-around
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
      idle();
      chk("wrap_pc", pc_o, 32'h0);
      for (int i = 0; i < 4; i++) idle();

      // Asynchronous reset mid-stream
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("arst_pc", pc_o, 32'h0);
      chk("arst_v", {31'h0, link_valid_o}, 32'h0);
      chk("arst_cnt", {16'h0, redirect_cnt_o}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      chk_all();

      // Counter saturation
      for (int i = 0; i < 65540; i++)
         step(1'b0, 1'b0, 32'h0, 1'b1, $urandom);
      chk("sat_cnt", {16'h0, redirect_cnt_o}, 32'hFFFF);

      // Random traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom,
              $urandom_range(0, 5) == 0, $urandom);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the RV32I pipeline: owns the fetch PC register, selects the next PC among sequential, predictor target and EX-stage redirect, and carries each fetched instruction's PC+INC down a valid-tagged shift chain so the MEM stage receives its link value. It applies stall (hold plus bubble) and redirect (kill) rules. It replaces the bare combinational PC+4 adder used at MEM.

## Interface
- XLEN, 32, PC and data width
- RESET_VECTOR, 32'h0000_0000, fetch PC after reset
- INC, 4, sequential increment
- LINK_STAGES, 3, chain length; stage LINK_STAGES drives the MEM outputs (≥2)
- HOLD_STAGES, 1, stages 1..HOLD_STAGES held on stall (< LINK_STAGES)
- KILL_STAGES, 2, stages 1..KILL_STAGES invalidated on redirect (< LINK_STAGES)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- stall_i  in  1  freeze fetch PC and held stages
- pred_taken_i  in  1  predictor says the current fetch PC is taken
- pred_target_i  in  XLEN  predicted target
- redirect_i  in  1  EX correction: mispredict or jump resolved
- redirect_pc_i  in  XLEN  corrected PC
- pc_o  out  XLEN  current fetch PC (registered)
- link_valid_o  out  1  stage LINK_STAGES holds a real instruction
- link_pc_o  out  XLEN  PC+INC of that instruction
- misalign_o  out  1  one-cycle pulse: accepted redirect had bit 1 set
- redirect_cnt_o  out  16  saturating count of accepted redirects

## Operation
- Reset (async, any cycle): pc_o=RESET_VECTOR; all stage valid=0 and value=0; misalign_o=0; redirect_cnt_o=0. Reset mid-operation discards in-flight stages immediately.
- Next-PC priority per edge: redirect_i > stall_i (hold) > pred_taken_i > pc_o+INC.
- Redirect: pc_o <= {redirect_pc_i[XLEN-1:2],2'b00}. misalign_o <= redirect_pc_i[1]. redirect_cnt_o increments and saturates at 16'hFFFF.
- Fetch slot is always valid after reset release. Stage 1 captures {1, pc_o+INC}, with the sum computed from the pre-edge pc_o.
- Stage k (k≥2) captures stage k-1.
- Stall without redirect:
  - pc_o and stages 1..HOLD_STAGES keep their contents.
  - Stage HOLD_STAGES+1 loads valid=0, value=0 (bubble).
  - Stages above it advance normally.
- Redirect, with or without stall:
  - Stages 1..KILL_STAGES load valid=0, value=0.
  - Stage KILL_STAGES+1 captures stage KILL_STAGES normally, so the redirecting instruction survives.
  - Stages above advance.
  - The stall is ignored that cycle.
- Arithmetic is modulo 2^XLEN: XLEN'hFFFF_FFFC + 4 = 0, with no flag.
- pred_target_i is taken unmodified.
- An invalid stage value is always 0, so link_pc_o=0 whenever link_valid_o=0.

## Timing
- All outputs are registered. There are no combinational input-to-output paths.
- pc_o shows the selected next PC one cycle after the edge that samples the inputs.
- Link latency is LINK_STAGES cycles: the PC fetched in cycle t appears on link_pc_o in cycle t+LINK_STAGES when there is no stall or kill. Each stall cycle adds one cycle for held instructions.
- The first link_valid_o is asserted LINK_STAGES cycles after reset deassertion.
- misalign_o is high for exactly the one cycle after the accepting edge.
- Redirect and stall in the same cycle: redirect wins fully (PC load, kill, no hold).
- Back-to-back redirects: each is accepted and counted. The counter holds at 16'hFFFF.

## Test plan
- Reset then free-run (defaults):
  - Required pc_o sequence: 0, 4, 8, 12.
  - link_valid_o first rises in cycle 3, with link_pc_o=4, then 8, 12.
- Predict then redirect:
  - At pc_o=8, pulse pred_taken_i with target 0x100. Required: pc_o=0x100 next cycle.
  - Two cycles later, pulse redirect_i with redirect_pc_i=0x40. Required: pc_o=0x40, redirect_cnt_o=1.
  - The two younger stages emerge at MEM as link_valid_o=0 with link_pc_o=0.
- Stall for 2 cycles with pc_o=0x20:
  - Required: pc_o holds 0x20, stage 1 holds.
  - Two bubbles reach MEM (link_valid_o=0 for two cycles).
  - Then the sequence resumes with link_pc_o=0x20 order preserved.
- Redirect asserted together with stall_i, redirect_pc_i=0x82:
  - Required: pc_o=0x80.
  - misalign_o pulses for one cycle.
  - Stall is ignored and the kill is applied.
- Wrap-around: redirect to 0xFFFF_FFFC, then run. Required: pc_o=0 next, with link_pc_o=0 later carrying link_valid_o=1.
- Assert rst mid-stream with valid stages in flight:
  - Required immediately (asynchronous): pc_o=RESET_VECTOR, link_valid_o=0, redirect_cnt_o=0.
- Force 65536 redirects: redirect_cnt_o saturates at 0xFFFF.
